// File: rtl/wave_lut_loader.sv
// Byte-stream loader for the wave_gen lookup table: fills a shadow table, then commits it to lut_out in one clock.
// Optional trailing checksum byte (sum of data bytes mod 256) enabled by defining LUT_CHECKSUM_EN.
module wave_lut_loader #(
    parameter int LUT_SIZE    = 4096,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic [LUT_SIZE-1:0] lut_out,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         byte_count
);

    localparam int N     = LUT_SIZE / 8;
    localparam int IDX_W = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1;
    localparam int GAP_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [15:0]      LAST_IDX  = 16'(N - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
`ifdef LUT_CHECKSUM_EN
    localparam logic [1:0] S_CHK    = 2'd2;
`endif
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]          state_q,  state_d;
    logic [15:0]         count_q,  count_d;
    logic [GAP_W-1:0]    gap_q,    gap_d;
    logic [LUT_SIZE-1:0] shadow_q, shadow_d;
    logic [LUT_SIZE-1:0] lut_q,    lut_d;
    logic                done_q,   done_d;
    logic                err_q,    err_d;
`ifdef LUT_CHECKSUM_EN
    logic [7:0]          sum_q,    sum_d;
`endif

    logic             xfer;
    logic [IDX_W-1:0] wr_lsb;

`ifdef LUT_CHECKSUM_EN
    assign byte_ready = (state_q == S_LOAD) || (state_q == S_CHK);
`else
    assign byte_ready = (state_q == S_LOAD);
`endif

    assign xfer   = byte_valid && byte_ready;
    // Byte i of the load lands at bit 8*i, so byte 0 ends up in lut_out[7:0].
    assign wr_lsb = IDX_W'({count_q, 3'b000});

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path through the case infers a latch.
        state_d  = state_q;
        count_d  = count_q;
        gap_d    = gap_q;
        shadow_d = shadow_q;
        lut_d    = lut_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef LUT_CHECKSUM_EN
        sum_d    = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    gap_d   = '0;
`ifdef LUT_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end

            S_LOAD: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (start) begin
                    count_d = '0;
                    gap_d   = '0;
`ifdef LUT_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end else if (xfer) begin
                    shadow_d[wr_lsb +: 8] = byte_in;
                    count_d = count_q + 16'd1;
                    gap_d   = '0;
`ifdef LUT_CHECKSUM_EN
                    sum_d   = sum_q + byte_in;
                    if (count_q == LAST_IDX) state_d = S_CHK;
`else
                    if (count_q == LAST_IDX) state_d = S_COMMIT;
`endif
                end else if (gap_q == GAP_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

`ifdef LUT_CHECKSUM_EN
            S_CHK: begin
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_LOAD;
                    count_d = '0;
                    gap_d   = '0;
                    sum_d   = '0;
                end else if (xfer) begin
                    gap_d = '0;
                    if (byte_in == sum_q) begin
                        state_d = S_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (gap_q == GAP_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
`endif

            S_COMMIT: begin
                // Whole table swaps in a single edge so wave_gen never sees a partial table.
                lut_d   = shadow_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shadow table is plain flops, not RAM, so it is cleared by reset like any other register.
            state_q  <= S_IDLE;
            count_q  <= '0;
            gap_q    <= '0;
            shadow_q <= '0;
            lut_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef LUT_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking here so all registers update from the same pre-edge values.
            state_q  <= state_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            shadow_q <= shadow_d;
            lut_q    <= lut_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef LUT_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign lut_out    = lut_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign byte_count = count_q;

endmodule
